// File: rtl/h264ct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | h264ct_pkg                                                                  |
// | Shared types and constants for the H.264 core-transform block scheduler.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package h264ct_pkg;

   localparam int ROWS_PER_BLK    = 4;
   localparam int DEF_ROW_W       = 36;
   localparam int DEF_LUMA_BLKS   = 16;
   localparam int DEF_CHROMA_BLKS = 8;
   localparam int BLK_IDX_W       = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_BURST = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef logic [DEF_ROW_W-1:0] row_t;

   function automatic logic is_chroma(input logic [BLK_IDX_W-1:0] idx, input int luma_blks);
      return (int'(idx) >= luma_blks);
   endfunction

endpackage
`default_nettype wire

// File: rtl/h264ct_row_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | h264ct_row_buffer                                                           |
// | Four-row fill/burst buffer: write pointer, full flag and read-index mux.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module h264ct_row_buffer
   import h264ct_pkg::*;
#(
   parameter int ROW_W = DEF_ROW_W
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_data,
   input  logic [1:0]       rd_idx,
   output logic [2:0]       rows_held,
   output logic             full,
   output logic [ROW_W-1:0] rd_data
);

   logic [2:0]       wr_ptr_d, wr_ptr_q;
   logic             wr_fire;
   logic [ROW_W-1:0] mem_q [ROWS_PER_BLK];

   assign full      = (wr_ptr_q == 3'(ROWS_PER_BLK));
   assign rows_held = wr_ptr_q;
   assign rd_data   = mem_q[rd_idx];

   always_comb begin
      wr_fire  = wr_en && !full;
      wr_ptr_d = wr_ptr_q;
      if (clr) begin
         wr_ptr_d = 3'd0;
      end else if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + 3'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         wr_ptr_q <= 3'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Contents need no reset: they are only read after four fresh writes.
   always_ff @(posedge CLK) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q[1:0]] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/h264coretransform_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | h264coretransform_scheduler                                                 |
// | Feeds 16 luma + 8 chroma 4x4 blocks of a macroblock to the core transform.  |
// | Optional HCT_STALL_CNT_EN adds the STALL_CYCLES source-idle counter.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module h264coretransform_scheduler
   import h264ct_pkg::*;
#(
   parameter int ROW_W       = DEF_ROW_W,
   parameter int LUMA_BLKS   = DEF_LUMA_BLKS,
   parameter int CHROMA_BLKS = DEF_CHROMA_BLKS,
   parameter int BLK_PERIOD  = 8,
   parameter int XFORM_LAT   = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             MB_START,
   input  logic             LUMA_VALID,
   input  logic [ROW_W-1:0] LUMA_ROW,
   output logic             LUMA_READY,
   input  logic             CHROMA_VALID,
   input  logic [ROW_W-1:0] CHROMA_ROW,
   output logic             CHROMA_READY,
   output logic             XFORM_ENABLE,
   output logic             XFORM_VALID,
   output logic [ROW_W-1:0] XFORM_ROW,
   output logic             XFORM_CCHAN,
   output logic [4:0]       BLK_IDX,
   output logic             BUSY,
   output logic             MB_DONE
`ifdef HCT_STALL_CNT_EN
   ,
   output logic [15:0]      STALL_CYCLES
`endif
);

   localparam logic [4:0] LAST_BLK   = 5'(LUMA_BLKS + CHROMA_BLKS - 1);
   localparam logic [3:0] COOL_LOAD  = 4'(BLK_PERIOD - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(XFORM_LAT - 1);

   state_t           state_d, state_q;
   logic [4:0]       blk_idx_d, blk_idx_q;
   logic [3:0]       cooldown_d, cooldown_q;
   logic [1:0]       burst_k_d, burst_k_q;
   logic [3:0]       drain_cnt_d, drain_cnt_q;

   logic             sel_chroma;
   logic             src_valid;
   logic [ROW_W-1:0] src_row;
   logic             fill_ready;
   logic             row_accept;
   logic             full_next;
   logic             buf_clr;
   logic             start_accept;
   logic [2:0]       buf_rows;
   logic             buf_full;
   logic [ROW_W-1:0] buf_rd_data;

   assign sel_chroma = is_chroma(blk_idx_q, LUMA_BLKS);
   assign src_valid  = sel_chroma ? CHROMA_VALID : LUMA_VALID;
   assign src_row    = sel_chroma ? CHROMA_ROW : LUMA_ROW;
   assign fill_ready = (state_q == ST_FILL) && !buf_full;
   assign row_accept = fill_ready && src_valid;
   // Counting the row arriving this cycle lets the burst follow the 4th row directly.
   assign full_next  = buf_full || ((buf_rows == 3'(ROWS_PER_BLK - 1)) && row_accept);

   h264ct_row_buffer #(
      .ROW_W (ROW_W)
   ) u_row_buffer (
      .CLK       (CLK),
      .RESET     (RESET),
      .clr       (buf_clr),
      .wr_en     (row_accept),
      .wr_data   (src_row),
      .rd_idx    (burst_k_q),
      .rows_held (buf_rows),
      .full      (buf_full),
      .rd_data   (buf_rd_data)
   );

   always_comb begin
      state_d      = state_q;
      blk_idx_d    = blk_idx_q;
      burst_k_d    = burst_k_q;
      drain_cnt_d  = drain_cnt_q;
      cooldown_d   = (cooldown_q != 4'd0) ? (cooldown_q - 4'd1) : 4'd0;
      buf_clr      = 1'b0;
      start_accept = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (MB_START) begin
               state_d      = ST_FILL;
               blk_idx_d    = 5'd0;
               buf_clr      = 1'b1;
               start_accept = 1'b1;
            end
         end
         ST_FILL: begin
            if (full_next && (cooldown_q == 4'd0)) begin
               state_d    = ST_BURST;
               burst_k_d  = 2'd0;
               // Loaded on entry so the count already reads BLK_PERIOD-1 at row 0.
               cooldown_d = COOL_LOAD;
            end
         end
         ST_BURST: begin
            burst_k_d = burst_k_q + 2'd1;
            if (burst_k_q == 2'd3) begin
               buf_clr = 1'b1;
               if (blk_idx_q == LAST_BLK) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = 4'd0;
               end else begin
                  state_d   = ST_FILL;
                  blk_idx_d = blk_idx_q + 5'd1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = ST_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            blk_idx_d = 5'd0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         blk_idx_q   <= 5'd0;
         cooldown_q  <= 4'd0;
         burst_k_q   <= 2'd0;
         drain_cnt_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         blk_idx_q   <= blk_idx_d;
         cooldown_q  <= cooldown_d;
         burst_k_q   <= burst_k_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign LUMA_READY   = fill_ready && !sel_chroma;
   assign CHROMA_READY = fill_ready && sel_chroma;
   assign XFORM_VALID  = (state_q == ST_BURST);
   assign XFORM_ENABLE = (state_q == ST_BURST) && (burst_k_q == 2'd0);
   assign XFORM_ROW    = (state_q == ST_BURST) ? buf_rd_data : '0;
   assign XFORM_CCHAN  = sel_chroma;
   assign BLK_IDX      = blk_idx_q;
   assign BUSY         = (state_q != ST_IDLE);
   assign MB_DONE      = (state_q == ST_DONE);

`ifdef HCT_STALL_CNT_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (start_accept) begin
         stall_cnt_d = 16'd0;
      end else if (fill_ready && !src_valid && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign STALL_CYCLES = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_h264coretransform_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_h264coretransform_scheduler                                              |
// | Vector table plus timestamp reference model for the block scheduler.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_h264coretransform_scheduler;
   import h264ct_pkg::*;

   localparam int NL     = 16;
   localparam int NC     = 8;
   localparam int NB     = NL + NC;
   localparam int PERIOD = 8;
   localparam int LAT    = 5;

   logic        CLK = 1'b0;
   logic        RESET, MB_START, LUMA_VALID, CHROMA_VALID;
   logic [35:0] LUMA_ROW, CHROMA_ROW, XFORM_ROW;
   logic        LUMA_READY, CHROMA_READY, XFORM_ENABLE, XFORM_VALID, XFORM_CCHAN, BUSY, MB_DONE;
   logic [4:0]  BLK_IDX;
`ifdef HCT_STALL_CNT_EN
   logic [15:0] STALL_CYCLES;
`endif

   always #5 CLK = ~CLK;

   h264coretransform_scheduler #(
      .ROW_W(36), .LUMA_BLKS(NL), .CHROMA_BLKS(NC), .BLK_PERIOD(PERIOD), .XFORM_LAT(LAT)
   ) dut (
      .CLK(CLK), .RESET(RESET), .MB_START(MB_START),
      .LUMA_VALID(LUMA_VALID), .LUMA_ROW(LUMA_ROW), .LUMA_READY(LUMA_READY),
      .CHROMA_VALID(CHROMA_VALID), .CHROMA_ROW(CHROMA_ROW), .CHROMA_READY(CHROMA_READY),
      .XFORM_ENABLE(XFORM_ENABLE), .XFORM_VALID(XFORM_VALID), .XFORM_ROW(XFORM_ROW),
      .XFORM_CCHAN(XFORM_CCHAN), .BLK_IDX(BLK_IDX), .BUSY(BUSY), .MB_DONE(MB_DONE)
`ifdef HCT_STALL_CNT_EN
      , .STALL_CYCLES(STALL_CYCLES)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: block progress tracked by row counts and burst timestamps.
   bit   m_active;
   int   m_blk, m_rows, m_bs, m_done_at, m_prev_en, m_stall;
   row_t m_q[$];
   bit   chk_en = 1'b0;

   int n_en, last_en, min_gap, max_gap, last_val, done_cyc, n_done;
   int en_cyc[32];

   task automatic clear_obs();
      n_en = 0; last_en = 0; min_gap = 1000000; max_gap = 0;
      last_val = 0; done_cyc = 0; n_done = 0;
   endtask

   task automatic observe();
      int gap;
      if (XFORM_ENABLE) begin
         if (n_en > 0) begin
            gap = cyc - last_en;
            if (gap < min_gap) min_gap = gap;
            if (gap > max_gap) max_gap = gap;
         end
         if (n_en < 32) en_cyc[n_en] = cyc;
         last_en = cyc;
         n_en++;
      end
      if (XFORM_VALID) last_val = cyc;
      if (MB_DONE) begin
         done_cyc = cyc;
         n_done++;
      end
   endtask

   task automatic model_step();
      bit   in_burst, e_ready, sel_v;
      row_t sel_d;
      if (!RESET) begin
         m_active = 1'b0; m_blk = 0; m_rows = 0; m_prev_en = -1000; m_stall = 0;
         m_q.delete();
         return;
      end
      in_burst = m_active && (m_blk < NB) && (m_rows == 4) && (cyc >= m_bs) && (cyc <= m_bs + 3);
      e_ready  = m_active && (m_blk < NB) && (m_rows < 4);
      chk("BUSY", BUSY, m_active);
      chk("LUMA_READY", LUMA_READY, e_ready && (m_blk < NL));
      chk("CHROMA_READY", CHROMA_READY, e_ready && (m_blk >= NL));
      chk("XFORM_VALID", XFORM_VALID, in_burst);
      chk("XFORM_ENABLE", XFORM_ENABLE, in_burst && (cyc == m_bs));
      chk("MB_DONE", MB_DONE, m_active && (m_blk == NB) && (cyc == m_done_at));
      if (in_burst) begin
         chk("XFORM_ROW", XFORM_ROW, m_q[cyc - m_bs]);
         chk("XFORM_CCHAN", XFORM_CCHAN, m_blk >= NL);
      end
      if (m_active) chk("BLK_IDX", BLK_IDX, (m_blk < NB) ? m_blk : NB - 1);
`ifdef HCT_STALL_CNT_EN
      if (m_active && (m_blk == NB) && (cyc == m_done_at)) chk("STALL_CYCLES", STALL_CYCLES, m_stall);
`endif
      if (!m_active) begin
         if (MB_START) begin
            m_active = 1'b1; m_blk = 0; m_rows = 0; m_stall = 0;
            m_q.delete();
         end
      end else if (m_blk < NB) begin
         sel_v = (m_blk < NL) ? LUMA_VALID : CHROMA_VALID;
         sel_d = (m_blk < NL) ? LUMA_ROW : CHROMA_ROW;
         if (e_ready) begin
            if (sel_v) begin
               m_q.push_back(sel_d);
               m_rows++;
               if (m_rows == 4) m_bs = (cyc + 1 > m_prev_en + PERIOD) ? cyc + 1 : m_prev_en + PERIOD;
            end else begin
               m_stall++;
            end
         end
         if (in_burst && (cyc == m_bs)) m_prev_en = cyc;
         if (in_burst && (cyc == m_bs + 3)) begin
            m_q.delete();
            m_rows = 0;
            m_blk++;
            if (m_blk == NB) m_done_at = cyc + 1 + LAT;
         end
      end else if (cyc == m_done_at) begin
         m_active = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      cyc++;
      observe();
      if (chk_en) model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit s, input bit lv, input bit cv);
      MB_START     = s;
      LUMA_VALID   = lv;
      CHROMA_VALID = cv;
      LUMA_ROW     = {4'($urandom), $urandom};
      CHROMA_ROW   = {4'($urandom), $urandom};
      tick();
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      drive(1, 1, 1);
      drive(1, 1, 1);
      RESET = 1'b1;
   endtask

   typedef struct {
      bit          rst_n, start, lv;
      logic [35:0] lrow;
      bit          chkf, busy, lrdy, crdy, xv, xen, done;
      logic [4:0]  blk;
      logic [35:0] xrow;
   } vec_t;

   function automatic vec_t mkv(bit rst_n, bit st, bit lv, logic [35:0] lrow, bit chkf,
                                bit busy, bit lrdy, bit xv, bit xen, logic [4:0] blk, logic [35:0] xrow);
      vec_t v;
      v.rst_n = rst_n; v.start = st; v.lv = lv; v.lrow = lrow; v.chkf = chkf;
      v.busy = busy; v.lrdy = lrdy; v.crdy = 1'b0; v.xv = xv; v.xen = xen; v.done = 1'b0;
      v.blk = blk; v.xrow = xrow;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[12];
      logic [35:0] ra, rb, rc, rd;
      bit          lv, pulsed, found;
      int          n_stall, last_inj;

      ra = 36'h123456789; rb = 36'h9ABCDEF01; rc = 36'h0F0F0F0F0; rd = 36'hFEDCBA987;
      //             rst st lv lrow chk busy lr xv xen blk xrow
      vecs[0]  = mkv(0, 1, 1, ra, 0, 0, 0, 0, 0, 5'd0, 36'h0);
      vecs[1]  = mkv(0, 1, 1, ra, 1, 0, 0, 0, 0, 5'd0, 36'h0);
      vecs[2]  = mkv(1, 1, 1, ra, 1, 0, 0, 0, 0, 5'd0, 36'h0);
      vecs[3]  = mkv(1, 0, 1, ra, 1, 1, 1, 0, 0, 5'd0, 36'h0);
      vecs[4]  = mkv(1, 0, 1, rb, 1, 1, 1, 0, 0, 5'd0, 36'h0);
      vecs[5]  = mkv(1, 0, 1, rc, 1, 1, 1, 0, 0, 5'd0, 36'h0);
      vecs[6]  = mkv(1, 0, 1, rd, 1, 1, 1, 0, 0, 5'd0, 36'h0);
      vecs[7]  = mkv(1, 0, 1, 36'h0, 1, 1, 0, 1, 1, 5'd0, ra);
      vecs[8]  = mkv(1, 0, 1, 36'h0, 1, 1, 0, 1, 0, 5'd0, rb);
      vecs[9]  = mkv(1, 0, 1, 36'h0, 1, 1, 0, 1, 0, 5'd0, rc);
      vecs[10] = mkv(1, 0, 1, 36'h0, 1, 1, 0, 1, 0, 5'd0, rd);
      vecs[11] = mkv(1, 0, 1, 36'h0, 1, 1, 1, 0, 0, 5'd1, 36'h0);

      RESET = 1'b0; MB_START = 1'b0; LUMA_VALID = 1'b0; CHROMA_VALID = 1'b0;
      LUMA_ROW = '0; CHROMA_ROW = '0;
      clear_obs();
      @(posedge CLK);
      #1;

      for (int i = 0; i < 12; i++) begin
         RESET = vecs[i].rst_n; MB_START = vecs[i].start;
         LUMA_VALID = vecs[i].lv; CHROMA_VALID = 1'b1;
         LUMA_ROW = vecs[i].lrow; CHROMA_ROW = 36'h555555555;
         @(negedge CLK);
         cyc++;
         if (vecs[i].chkf) begin
            chk("tbl_BUSY", BUSY, vecs[i].busy);
            chk("tbl_LUMA_READY", LUMA_READY, vecs[i].lrdy);
            chk("tbl_CHROMA_READY", CHROMA_READY, vecs[i].crdy);
            chk("tbl_XFORM_VALID", XFORM_VALID, vecs[i].xv);
            chk("tbl_XFORM_ENABLE", XFORM_ENABLE, vecs[i].xen);
            chk("tbl_MB_DONE", MB_DONE, vecs[i].done);
            chk("tbl_BLK_IDX", BLK_IDX, vecs[i].blk);
            if (vecs[i].xv || !vecs[i].busy) chk("tbl_XFORM_ROW", XFORM_ROW, vecs[i].xrow);
         end
         @(posedge CLK);
         #1;
      end

      chk_en = 1'b1;

      // Full macroblock with both sources always valid.
      do_reset();
      clear_obs();
      drive(1, 1, 1);
      for (int i = 0; i < 400 && n_done == 0; i++) drive(0, 1, 1);
      chk("full_mb_done_seen", n_done, 1);
      chk("full_mb_enables", n_en, NB);
      chk("full_mb_min_gap", min_gap, PERIOD);
      chk("full_mb_max_gap", max_gap, PERIOD);
      chk("full_mb_done_lat", done_cyc - last_val, LAT + 1);

      // Luma stall on block 2 plus an ignored MB_START at block 7.
      clear_obs();
      drive(1, 1, 1);
      n_stall = 0; pulsed = 1'b0;
      for (int i = 0; i < 400 && n_done == 0; i++) begin
         lv = 1'b1;
         if (m_active && m_blk == 2 && m_rows == 2 && n_stall < 3) begin
            lv = 1'b0;
            n_stall++;
         end
         if (m_active && m_blk == 7 && !pulsed) begin
            pulsed = 1'b1;
            drive(1, lv, 1);
         end else begin
            drive(0, lv, 1);
         end
      end
      chk("stall_mb_done_seen", n_done, 1);
      chk("stall_mb_enables", n_en, NB);
      chk("stall_blk2_gap", en_cyc[2] - en_cyc[1], PERIOD + 3);
      chk("stall_blk3_gap", en_cyc[3] - en_cyc[2], PERIOD);
      chk("stall_done_time", done_cyc - en_cyc[0], 23 * PERIOD + 3 + 3 + LAT + 1);

`ifdef HCT_STALL_CNT_EN
      clear_obs();
      drive(1, 1, 1);
      last_inj = -1;
      for (int i = 0; i < 600 && n_done == 0; i++) begin
         lv = 1'b1;
         if (m_active && m_blk < 10 && m_rows == 1 && last_inj != m_blk) begin
            lv = 1'b0;
            last_inj = m_blk;
         end
         drive(0, lv, 1);
      end
      chk("stall_cnt_at_done", STALL_CYCLES, 16'd10);
      drive(1, 1, 1);
      chk("stall_cnt_after_start", STALL_CYCLES, 16'd0);
      do_reset();
`endif

      // Reset while block 5 is at burst row 2.
      clear_obs();
      drive(1, 1, 1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_active && m_blk == 5 && m_rows == 4 && (cyc + 1 == m_bs + 2)) begin
            found = 1'b1;
            break;
         end
         drive(0, 1, 1);
      end
      chk("abort_reached_k2", found, 1'b1);
      chk("abort_valid_at_k2", XFORM_VALID, 1'b1);
      RESET = 1'b0;
      drive(0, 1, 1);
      RESET = 1'b1;
      chk("abort_valid_after", XFORM_VALID, 1'b0);
      chk("abort_busy_after", BUSY, 1'b0);
      n_done = 0;
      for (int i = 0; i < 100; i++) drive(0, 1, 1);
      chk("abort_no_done", n_done, 0);

      // Randomised sources and stray MB_START pulses.
      for (int mb = 0; mb < 3; mb++) begin
         clear_obs();
         drive(1, 1'($urandom), 1'($urandom));
         for (int i = 0; i < 2000 && n_done == 0; i++)
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         chk("rand_mb_done_seen", n_done, 1);
         chk("rand_mb_enables", n_en, NB);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/h264coretransform_scheduler.md
Name: h264coretransform_scheduler

Overview:
Sequences one macroblock of residual data through the shared 4x4 core-transform pipeline: 16 luma blocks, then 8 chroma blocks.
- Each block's 4 rows are collected from the selected source through a valid/ready handshake.
- Rows are released to the transform as a gap-free 4-cycle burst, with a start pulse on the first row.
- Bursts are spaced by a minimum period so the downstream pipeline-enable sequencer is back in its idle state before the next block.
- After the last block drains, the block signals macroblock completion.

Parameters:
ROW_W, 36, width of one residual row (4 x 9-bit samples)
LUMA_BLKS, 16, luma 4x4 blocks per macroblock
CHROMA_BLKS, 8, chroma 4x4 blocks per macroblock (Cb then Cr)
BLK_PERIOD, 8, minimum cycles between successive XFORM_ENABLE pulses; legal range 4..15
XFORM_LAT, 5, cycles after the last burst row before the transform output is complete

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-low reset
MB_START  in  1  one-cycle pulse that starts a macroblock; honoured only in IDLE
LUMA_VALID  in  1  luma row available
LUMA_ROW  in  ROW_W  luma row data
LUMA_READY  out  1  scheduler accepts a luma row this cycle
CHROMA_VALID  in  1  chroma row available
CHROMA_ROW  in  ROW_W  chroma row data
CHROMA_READY  out  1  scheduler accepts a chroma row this cycle
XFORM_ENABLE  out  1  one-cycle start pulse, coincident with row 0 of each burst
XFORM_VALID  out  1  XFORM_ROW is valid
XFORM_ROW  out  ROW_W  row presented to the core transform
XFORM_CCHAN  out  1  0 = luma block, 1 = chroma block (held through the burst)
BLK_IDX  out  5  index 0..23 of the block being filled or bursted
BUSY  out  1  high whenever state is not IDLE
MB_DONE  out  1  one-cycle pulse when the macroblock is complete

Behaviour:
- Reset (RESET=0 at a clock edge):
  - state becomes IDLE; row count, BLK_IDX, cooldown and burst index all clear to 0.
  - every output reads 0 from the next cycle; buffer contents are don't-care.
- States: IDLE, FILL, BURST, DRAIN, DONE.
- IDLE:
  - MB_START=1 -> FILL, with BLK_IDX=0.
  - Otherwise stay in IDLE.
- Source select: BLK_IDX < LUMA_BLKS selects luma; otherwise chroma. Only the selected source's READY may be high.
- FILL:
  - READY = (rows_held < 4).
  - A row is accepted when VALID && READY and written to buffer[rows_held].
  - Transition to BURST when rows_held == 4 and cooldown == 0.
  - A 4th row accepted at edge t with cooldown already 0 gives BURST in the cycle after edge t, i.e. one cycle of latency.
- BURST (4 cycles, burst index k = 0..3):
  - XFORM_VALID=1 and XFORM_ROW=buffer[k]; outputs are decoded combinationally from registered state.
  - XFORM_ENABLE=1 only when k=0.
  - cooldown loads BLK_PERIOD-1 at k=0, then decrements to 0 and saturates there.
  - READY=0 throughout the burst.
  - After k=3: rows_held clears to 0. If BLK_IDX == LUMA_BLKS+CHROMA_BLKS-1 -> DRAIN; else BLK_IDX increments -> FILL.
- The burst is never interrupted: rows are emitted on 4 consecutive cycles regardless of source stalls.
- DRAIN: counts XFORM_LAT cycles, then -> DONE.
- DONE: MB_DONE=1 for one cycle, then -> IDLE.
- MB_START while BUSY is ignored.
- Source VALID with READY=0 causes no state change; the source holds its data.
- Reset asserted mid-FILL, mid-BURST or mid-DRAIN aborts immediately: no further XFORM_VALID and no MB_DONE.
- XFORM_CCHAN = (BLK_IDX >= LUMA_BLKS) and is stable across each burst.

Optional Feature:
- Macro: HCT_STALL_CNT_EN.
- Defined:
  - Adds output STALL_CYCLES, 16 bits.
  - Counts FILL cycles where the selected source has READY=1 and VALID=0.
  - Saturates at 16'hFFFF.
  - Clears on an accepted MB_START and on reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package h264ct_pkg:
  - state enum (IDLE, FILL, BURST, DRAIN, DONE)
  - ROWS_PER_BLK=4
  - default LUMA_BLKS and CHROMA_BLKS values
  - row typedef logic [ROW_W-1:0]
- Sub-module h264ct_row_buffer: 4-entry fill/burst buffer with write pointer, full flag and read-index mux. FSM, counters and handshakes stay in the top level.

Test Plan:
- Reset: RESET=0 for 2 cycles while MB_START=1 and both VALID=1 -> all outputs 0 and BUSY=0; the first cycle after release is still IDLE.
- Full macroblock, both VALID held at 1 -> 24 XFORM_ENABLE pulses spaced exactly 8 cycles apart:
  - XFORM_CCHAN=0 for BLK_IDX 0..15 and 1 for 16..23.
  - MB_DONE occurs 6 cycles after the last XFORM_VALID.
- Luma stall: LUMA_VALID=0 for 3 cycles after row 1 of block 2 -> the burst starts 3 cycles later; rows 0..3 are emitted on consecutive cycles, in order, with data matching the inputs.
- Cooldown: BLK_PERIOD=8, next buffer full 5 cycles after an ENABLE -> BURST waits until 8 cycles after that ENABLE; READY=0 during the wait.
- MB_START pulsed at BLK_IDX=7 -> ignored; block count and MB_DONE timing are unchanged. Reset asserted at BURST k=2 -> XFORM_VALID=0 the next cycle and no MB_DONE occurs.
- With HCT_STALL_CNT_EN: 10 injected source-idle cycles in FILL -> STALL_CYCLES=10 at MB_DONE, and 0 after the next MB_START.
